// File: rtl/crossbar_vc_rr.sv
`default_nettype none
// ============================================================================
//  Module   : crossbar_vc_rr
//  Purpose  : P_PORTS x P_PORTS buffered crossbar. Each (rx,tx) pair with
//             rx != tx owns one virtual-channel FIFO, which holds {last,data}
//             beats. Each tx port round-robins over its complete stored frames
//             and keeps its grant for a whole frame.
//  Ports    : clk_i, rst_i (async, active-high)
//             rx_valid_i/rx_data_i/rx_last_i/rx_dest_i : per-port ingress beats
//             tx_valid_o/tx_data_o/tx_last_o/tx_ready_i : per-port egress
//             drop_cnt_o : per-tx dropped-frame counters (16 bit each)
//  Options  : `define CROSSBAR_DROP_CNT_EN to add drop_cnt_o and its counters.
//  Revision : 1.0 - initial release
// ============================================================================
module crossbar_vc_rr #(
    parameter int P_PORTS            = 4,
    parameter int P_DATA_WIDTH       = 8,
    parameter int P_QUEUE_ADDR_WIDTH = 11,
    parameter int P_MAX_FRAME        = 1522
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [P_PORTS-1:0]                rx_valid_i,
    input  logic [P_PORTS*P_DATA_WIDTH-1:0]   rx_data_i,
    input  logic [P_PORTS-1:0]                rx_last_i,
    input  logic [P_PORTS*P_PORTS-1:0]        rx_dest_i,
    output logic [P_PORTS-1:0]                tx_valid_o,
    output logic [P_PORTS*P_DATA_WIDTH-1:0]   tx_data_o,
    output logic [P_PORTS-1:0]                tx_last_o,
    input  logic [P_PORTS-1:0]                tx_ready_i
`ifdef CROSSBAR_DROP_CNT_EN
    ,
    output logic [P_PORTS*16-1:0]             drop_cnt_o
`endif
);

    localparam int C_DEPTH = 1 << P_QUEUE_ADDR_WIDTH;
    localparam int C_PW    = $clog2(P_PORTS);
    localparam int C_CW    = P_QUEUE_ADDR_WIDTH + 1;
    localparam int C_EW    = P_DATA_WIDTH + 1;   // {last, data}

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } tx_state_t;

    // Cross-pair signals. Admission is indexed [rx*P+tx], request and head
    // are indexed [tx*P+rx] so each tx port sees a contiguous slice.
    logic [P_PORTS*P_PORTS-1:0]      w_admit_flat;
    logic [P_PORTS*P_PORTS-1:0]      w_req_flat;
    logic [P_PORTS*P_PORTS*C_EW-1:0] w_head_flat;

    // ---------------------------------------------------------------- RX side
    logic [P_PORTS-1:0] r_in_frame;
    logic [P_PORTS-1:0] r_acc     [P_PORTS];
    logic [P_PORTS-1:0] w_sof;
    logic [P_PORTS-1:0] w_mask    [P_PORTS];
    logic [P_PORTS-1:0] w_acc_now [P_PORTS];

    always_comb begin
        for (int p = 0; p < P_PORTS; p++) begin
            w_sof[p]     = rx_valid_i[p] & ~r_in_frame[p];
            // A port never forwards to itself.
            w_mask[p]    = rx_dest_i[p*P_PORTS +: P_PORTS] & ~(P_PORTS'(1) << p);
            // The accept mask is decided on SOF and frozen for the frame.
            w_acc_now[p] = w_sof[p] ? (w_mask[p] & w_admit_flat[p*P_PORTS +: P_PORTS])
                                    : r_acc[p];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_frame <= '0;
            for (int p = 0; p < P_PORTS; p++) r_acc[p] <= '0;
        end else begin
            for (int p = 0; p < P_PORTS; p++) begin
                if (rx_valid_i[p]) begin
                    r_in_frame[p] <= ~rx_last_i[p];
                    r_acc[p]      <= w_acc_now[p];
                end
            end
        end
    end

    // ---------------------------------------------------------------- TX FSM
    tx_state_t         r_state     [P_PORTS];
    tx_state_t         w_state_nxt [P_PORTS];
    logic [C_PW-1:0]   r_grant     [P_PORTS];
    logic [C_PW-1:0]   w_grant_nxt [P_PORTS];
    logic [C_PW-1:0]   r_ptr       [P_PORTS];
    logic [C_PW-1:0]   w_ptr_nxt   [P_PORTS];
    logic [C_PW-1:0]   w_pick      [P_PORTS];
    logic [P_PORTS-1:0] w_found;
    logic [P_PORTS-1:0] w_tx_pop;
    logic [C_EW-1:0]   w_head_sel  [P_PORTS];

    // ------------------------------------------------------------ VC FIFOs
    for (genvar gp = 0; gp < P_PORTS; gp++) begin : g_rx
        for (genvar gt = 0; gt < P_PORTS; gt++) begin : g_tx
            if (gp != gt) begin : g_vc
                logic [C_EW-1:0]               r_mem [C_DEPTH];
                logic [P_QUEUE_ADDR_WIDTH-1:0] r_wptr;
                logic [P_QUEUE_ADDR_WIDTH-1:0] r_rptr;
                logic [C_CW-1:0]               r_count;   // beats stored
                logic [C_CW-1:0]               r_fc;      // whole frames stored
                logic                          w_push;
                logic                          w_pop;
                logic                          w_push_last;
                logic                          w_pop_last;

                assign w_push      = rx_valid_i[gp] & w_acc_now[gp][gt];
                assign w_pop       = w_tx_pop[gt] & (r_grant[gt] == C_PW'(gp));
                assign w_push_last = w_push & rx_last_i[gp];
                assign w_pop_last  = w_pop & r_mem[r_rptr][C_EW-1];

                // Room for a maximum-size frame is required at SOF, which
                // is what makes overflow impossible later in the frame.
                assign w_admit_flat[gp*P_PORTS+gt] = (32'(r_count) + P_MAX_FRAME) <= C_DEPTH;
                assign w_req_flat[gt*P_PORTS+gp]   = (r_fc != '0);
                // First-word fall-through head.
                assign w_head_flat[(gt*P_PORTS+gp)*C_EW +: C_EW] = r_mem[r_rptr];

                always_ff @(posedge clk_i) begin
                    if (w_push) r_mem[r_wptr] <= {rx_last_i[gp], rx_data_i[gp*P_DATA_WIDTH +: P_DATA_WIDTH]};
                end

                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                        r_count <= '0;
                        r_fc    <= '0;
                    end else begin
                        if (w_push) r_wptr <= r_wptr + 1'b1;
                        if (w_pop)  r_rptr <= r_rptr + 1'b1;
                        case ({w_push, w_pop})
                            2'b10:   r_count <= r_count + 1'b1;
                            2'b01:   r_count <= r_count - 1'b1;
                            default: r_count <= r_count;
                        endcase
                        case ({w_push_last, w_pop_last})
                            2'b10:   r_fc <= r_fc + 1'b1;
                            2'b01:   r_fc <= r_fc - 1'b1;
                            default: r_fc <= r_fc;
                        endcase
                    end
                end
            end else begin : g_self
                assign w_admit_flat[gp*P_PORTS+gt]               = 1'b0;
                assign w_req_flat[gt*P_PORTS+gp]                 = 1'b0;
                assign w_head_flat[(gt*P_PORTS+gp)*C_EW +: C_EW] = '0;
            end
        end
    end

    // Output path: data and last are forced low whenever nothing is offered.
    always_comb begin
        for (int t = 0; t < P_PORTS; t++) begin
            w_head_sel[t] = w_head_flat[(t*P_PORTS + int'(r_grant[t]))*C_EW +: C_EW];
            tx_valid_o[t] = (r_state[t] == S_SEND);
            tx_last_o[t]  = (r_state[t] == S_SEND) & w_head_sel[t][C_EW-1];
            tx_data_o[t*P_DATA_WIDTH +: P_DATA_WIDTH] =
                (r_state[t] == S_SEND) ? w_head_sel[t][P_DATA_WIDTH-1:0] : '0;
        end
    end

    // Next-state: the requester search starts at ptr and wraps.
    always_comb begin
        for (int t = 0; t < P_PORTS; t++) begin
            w_state_nxt[t] = r_state[t];
            w_grant_nxt[t] = r_grant[t];
            w_ptr_nxt[t]   = r_ptr[t];
            w_tx_pop[t]    = 1'b0;
            w_found[t]     = 1'b0;
            w_pick[t]      = r_ptr[t];
            for (int i = 0; i < P_PORTS; i++) begin
                if (!w_found[t] && w_req_flat[t*P_PORTS + ((int'(r_ptr[t]) + i) % P_PORTS)]) begin
                    w_found[t] = 1'b1;
                    w_pick[t]  = C_PW'((int'(r_ptr[t]) + i) % P_PORTS);
                end
            end
            case (r_state[t])
                S_IDLE: begin
                    if (w_found[t]) begin
                        w_grant_nxt[t] = w_pick[t];
                        w_state_nxt[t] = S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready_i[t]) begin
                        w_tx_pop[t] = 1'b1;
                        if (w_head_sel[t][C_EW-1]) begin
                            w_ptr_nxt[t]   = (r_grant[t] == C_PW'(P_PORTS-1)) ? '0 : r_grant[t] + 1'b1;
                            w_state_nxt[t] = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt[t] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int t = 0; t < P_PORTS; t++) begin
                r_state[t] <= S_IDLE;
                r_grant[t] <= '0;
                r_ptr[t]   <= '0;
            end
        end else begin
            for (int t = 0; t < P_PORTS; t++) begin
                r_state[t] <= w_state_nxt[t];
                r_grant[t] <= w_grant_nxt[t];
                r_ptr[t]   <= w_ptr_nxt[t];
            end
        end
    end

`ifdef CROSSBAR_DROP_CNT_EN
    // ------------------------------------------------------ drop counters
    logic [15:0] r_drop_cnt  [P_PORTS];
    logic [16:0] w_drop_next [P_PORTS];

    // Every rx port that drops toward tx t on this cycle adds one; the extra
    // bit catches the carry so the counter can saturate.
    always_comb begin
        for (int t = 0; t < P_PORTS; t++) begin
            w_drop_next[t] = {1'b0, r_drop_cnt[t]};
            for (int p = 0; p < P_PORTS; p++) begin
                if (w_sof[p] && w_mask[p][t] && !w_admit_flat[p*P_PORTS+t])
                    w_drop_next[t] = w_drop_next[t] + 17'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int t = 0; t < P_PORTS; t++) r_drop_cnt[t] <= '0;
        end else begin
            for (int t = 0; t < P_PORTS; t++)
                r_drop_cnt[t] <= w_drop_next[t][16] ? 16'hFFFF : w_drop_next[t][15:0];
        end
    end

    for (genvar gt = 0; gt < P_PORTS; gt++) begin : g_drop_out
        assign drop_cnt_o[gt*16 +: 16] = r_drop_cnt[gt];
    end
`endif

endmodule
`default_nettype wire
